lock_sequencer: RTL and testbench
=================================

# lock_sequencer

- Synchronous controller for the keypad passcode lock.
- Sits between the keypad encoder and the two 8-digit shift-register arrays (user-input and stored-passcode) and their equality comparator.
- Replaces the ripple T-flip-flop clocking, the demux mode steering, the attempt counter and the alarm/unlock logic with one clocked FSM.
- Issues single-cycle shift/clear strobes, counts digits and failed attempts, and drives the unlocked and alarm indicators.

## Interface
- NUM_DIGITS, 8: digits per passcode, legal range 1..15.
- MAX_ATTEMPTS, 5: failed entries that raise the alarm, legal range 1..9.
- UNLOCK_CYCLES, 16: cycles `unlocked` stays high after a match.
- TIMEOUT_CYCLES, 255: idle cycles allowed between digits before a sequence is aborted.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- key_valid  in  1  keypad encoder valid bit (level, high while a key is held).
- key_code  in  4  BCD digit from the encoder, qualified by key_valid.
- prog_mode  in  1  1 = keys program the passcode, 0 = keys are an entry attempt.
- match  in  1  comparator output, combinational from the two register arrays.
- alarm_clr  in  1  synchronous alarm acknowledge.
- shift_data  out  4  registered key_code that accompanies a shift strobe.
- ui_shift  out  1  one-cycle strobe: shift shift_data into the user-input array.
- sp_shift  out  1  one-cycle strobe: shift shift_data into the passcode array.
- ui_clr  out  1  one-cycle strobe: clear the user-input array.
- digit_cnt  out  4  digits accepted in the current sequence.
- attempt_cnt  out  4  consecutive failed entries, binary, saturates at MAX_ATTEMPTS.
- code_set  out  1  a full passcode has been programmed since reset.
- unlocked  out  1  lock open.
- alarm  out  1  alarm active.

## Operation
- Key acceptance:
  - key_valid is registered as kv_q.
  - A keypress is kv_edge = key_valid & ~kv_q. One press is one digit, however long the key is held.
  - key_code and prog_mode are sampled on the kv_edge cycle.
- States: IDLE, PROG, ENTRY, CHECK, OPEN, ALARM.
- IDLE:
  - kv_edge with prog_mode=1 and code_set=0: go to PROG and accept the digit to the SP array.
  - kv_edge with prog_mode=0 and code_set=1: go to ENTRY and accept the digit to the UI array.
  - All other kv_edge cases are ignored.
- PROG:
  - Each kv_edge: sp_shift, digit_cnt+1.
  - When the accepted digit brings digit_cnt to NUM_DIGITS: set code_set, clear digit_cnt, return to IDLE.
  - prog_mode changes inside PROG are ignored.
- ENTRY:
  - Each kv_edge: ui_shift, digit_cnt+1.
  - At NUM_DIGITS: clear digit_cnt and go to CHECK.
- CHECK: exactly one cycle, so the comparator sees the final shifted array.
  - match=1: go to OPEN, clear attempt_cnt.
  - match=0: attempt_cnt+1 and pulse ui_clr. If the new count equals MAX_ATTEMPTS go to ALARM, otherwise go to IDLE.
- OPEN:
  - unlocked=1 for UNLOCK_CYCLES cycles, then ui_clr and return to IDLE.
  - A kv_edge with prog_mode=1 during OPEN clears code_set, ends OPEN immediately (ui_clr) and enters PROG with that digit accepted. This is re-programming.
  - Other keys are ignored.
- ALARM:
  - alarm=1; all keys are ignored.
  - alarm_clr: clear attempt_cnt, pulse ui_clr, go to IDLE.
- Timeout:
  - In PROG or ENTRY, TIMEOUT_CYCLES consecutive cycles without kv_edge abort to IDLE and clear digit_cnt.
  - An ENTRY timeout pulses ui_clr and does not charge an attempt.
  - A PROG timeout leaves code_set unchanged and does not clear the SP array (a partial shift is harmless because code_set gates entry).
- The timeout counter reloads on every accepted digit and on every state entry.

## Timing
- Reset, at the rising edge with rst=1:
  - State IDLE; kv_q=0.
  - All strobes, shift_data, digit_cnt, attempt_cnt, code_set, unlocked and alarm = 0.
  - Reset wins over every simultaneous event, including mid-sequence, OPEN and ALARM.
- Key latency:
  - key_valid rises before edge N, so kv_edge is true in the cycle ending at edge N.
  - shift_data, ui_shift/sp_shift and the incremented digit_cnt are registered at edge N and are valid for exactly one cycle after it (strobes are high only in cycle N+1).
- Final entry digit at edge N: CHECK is the state after N. The decision is taken at edge N+1 using match sampled then. unlocked or alarm is high from N+2.
- unlocked:
  - Rises at the edge that leaves CHECK.
  - Falls UNLOCK_CYCLES edges later; ui_clr is high in the first cycle it is low.
  - Re-programming drops it at the kv_edge edge.
- alarm_clr and kv_edge in the same ALARM cycle: alarm_clr is taken, the key is dropped.
- attempt_cnt never exceeds MAX_ATTEMPTS. With MAX_ATTEMPTS=1 the first failure goes straight to ALARM.
- A key held across a state change never produces a second accept until key_valid falls and rises again.

## Test plan
- Program 2,1,9,3,5,4,8,8 with prog_mode=1:
  - 8 sp_shift pulses with shift_data in that order.
  - code_set=1 after the 8th; digit_cnt returns to 0.
- Enter 2,1,9,3,5,4,8,8 with match=1 driven by the bench model:
  - 8 ui_shift pulses, one CHECK cycle, then unlocked=1 for 16 cycles, then a ui_clr pulse.
  - attempt_cnt=0 throughout.
- Five wrong entries (…8,7, match=0):
  - attempt_cnt goes 1,2,3,4,5, with a ui_clr pulse after each failure.
  - alarm=1 after the 5th; further keys give no strobes.
  - alarm_clr gives alarm=0 and attempt_cnt=0.
- Key held 20 cycles → exactly one strobe. Entry keys pressed before code_set=1 → no strobes.
- Timeout and reset:
  - 3 entry digits followed by 255 idle cycles → return to IDLE, ui_clr pulse, attempt_cnt unchanged.
  - rst asserted at digit 5 of programming → every output 0 next cycle and code_set=0.
- Re-program during OPEN:
  - kv_edge with prog_mode=1 gives unlocked=0 and a ui_clr pulse at that edge, with the sp_shift pulse in the next cycle.
  - 7 further digits give code_set=1.

Source files
------------

// File: rtl/lock_sequencer.sv
// Keypad passcode lock controller: edge-detects keys, steers digits to the user-input or
// passcode shift arrays, counts digits and failed attempts, and drives unlock/alarm.
module lock_sequencer #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned MAX_ATTEMPTS   = 5,
  parameter int unsigned UNLOCK_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       prog_mode,
  input  logic       match,
  input  logic       alarm_clr,
  output logic [3:0] shift_data,
  output logic       ui_shift,
  output logic       sp_shift,
  output logic       ui_clr,
  output logic [3:0] digit_cnt,
  output logic [3:0] attempt_cnt,
  output logic       code_set,
  output logic       unlocked,
  output logic       alarm
);

  localparam int unsigned TmrMax = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES
                                                                     : UNLOCK_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [3:0]      DigitsLast  = 4'(NUM_DIGITS);
  localparam logic [3:0]      AttemptsMax = 4'(MAX_ATTEMPTS);
  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmrW-1:0] UnlockLast  = TmrW'(UNLOCK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StProg, StEntry, StCheck, StOpen, StAlarm} state_e;

  state_e          state_q, state_d;
  logic            kv_q;
  logic [3:0]      shift_data_q, shift_data_d;
  logic            ui_shift_q, ui_shift_d;
  logic            sp_shift_q, sp_shift_d;
  logic            ui_clr_q, ui_clr_d;
  logic [3:0]      digit_cnt_q, digit_cnt_d;
  logic [3:0]      attempt_cnt_q, attempt_cnt_d;
  logic            code_set_q, code_set_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic       kv_edge;
  logic       accept_prog, accept_entry;
  logic [3:0] digit_inc;

  assign kv_edge   = key_valid & ~kv_q;
  assign digit_inc = digit_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      kv_q          <= 1'b0;
      shift_data_q  <= 4'd0;
      ui_shift_q    <= 1'b0;
      sp_shift_q    <= 1'b0;
      ui_clr_q      <= 1'b0;
      digit_cnt_q   <= 4'd0;
      attempt_cnt_q <= 4'd0;
      code_set_q    <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      kv_q          <= key_valid;
      shift_data_q  <= shift_data_d;
      ui_shift_q    <= ui_shift_d;
      sp_shift_q    <= sp_shift_d;
      ui_clr_q      <= ui_clr_d;
      digit_cnt_q   <= digit_cnt_d;
      attempt_cnt_q <= attempt_cnt_d;
      code_set_q    <= code_set_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_data_d  = shift_data_q;
    ui_shift_d    = 1'b0;
    sp_shift_d    = 1'b0;
    ui_clr_d      = 1'b0;
    digit_cnt_d   = digit_cnt_q;
    attempt_cnt_d = attempt_cnt_q;
    code_set_d    = code_set_q;
    // Timer restarts on every state entry and accepted digit; it only runs while held.
    timer_d       = '0;
    accept_prog   = 1'b0;
    accept_entry  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (kv_edge) begin
          if (prog_mode && !code_set_q)      accept_prog  = 1'b1;
          else if (!prog_mode && code_set_q) accept_entry = 1'b1;
        end
      end
      StProg: begin
        if (kv_edge) begin
          accept_prog = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          state_d     = StIdle;
          digit_cnt_d = 4'd0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StEntry: begin
        if (kv_edge) begin
          accept_entry = 1'b1;
        end else if (timer_q == TimeoutLast) begin
          state_d     = StIdle;
          digit_cnt_d = 4'd0;
          ui_clr_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCheck: begin
        if (match) begin
          state_d       = StOpen;
          attempt_cnt_d = 4'd0;
        end else begin
          attempt_cnt_d = attempt_cnt_q + 4'd1;
          ui_clr_d      = 1'b1;
          state_d       = (attempt_cnt_d == AttemptsMax) ? StAlarm : StIdle;
        end
      end
      StOpen: begin
        if (kv_edge && prog_mode) begin
          code_set_d  = 1'b0;
          ui_clr_d    = 1'b1;
          accept_prog = 1'b1;
        end else if (timer_q == UnlockLast) begin
          state_d  = StIdle;
          ui_clr_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StAlarm: begin
        if (alarm_clr) begin
          attempt_cnt_d = 4'd0;
          ui_clr_d      = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept_prog) begin
      sp_shift_d   = 1'b1;
      shift_data_d = key_code;
      if (digit_inc == DigitsLast) begin
        code_set_d  = 1'b1;
        digit_cnt_d = 4'd0;
        state_d     = StIdle;
      end else begin
        digit_cnt_d = digit_inc;
        state_d     = StProg;
      end
    end

    if (accept_entry) begin
      ui_shift_d   = 1'b1;
      shift_data_d = key_code;
      if (digit_inc == DigitsLast) begin
        digit_cnt_d = 4'd0;
        state_d     = StCheck;
      end else begin
        digit_cnt_d = digit_inc;
        state_d     = StEntry;
      end
    end
  end

  always_comb begin
    shift_data  = shift_data_q;
    ui_shift    = ui_shift_q;
    sp_shift    = sp_shift_q;
    ui_clr      = ui_clr_q;
    digit_cnt   = digit_cnt_q;
    attempt_cnt = attempt_cnt_q;
    code_set    = code_set_q;
    unlocked    = (state_q == StOpen);
    alarm       = (state_q == StAlarm);
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: programming, entry, failures/alarm, hold, timeout,
// re-programming from OPEN and reset during programming.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst, key_valid, prog_mode, match, alarm_clr;
  logic [3:0] key_code;
  logic [3:0] shift_data, digit_cnt, attempt_cnt;
  logic       ui_shift, sp_shift, ui_clr, code_set, unlocked, alarm;

  int total = 0;
  int bad   = 0;
  int n;

  logic [3:0] good_code  [8] = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd8};
  logic [3:0] wrong_code [8] = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd7};

  lock_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .prog_mode  (prog_mode),
    .match      (match),
    .alarm_clr  (alarm_clr),
    .shift_data (shift_data),
    .ui_shift   (ui_shift),
    .sp_shift   (sp_shift),
    .ui_clr     (ui_clr),
    .digit_cnt  (digit_cnt),
    .attempt_cnt(attempt_cnt),
    .code_set   (code_set),
    .unlocked   (unlocked),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Press a key: inputs change after an edge, accepted at the following edge.
  task automatic press(input logic [3:0] d, input logic pm);
    key_valid = 1'b1;
    key_code  = d;
    prog_mode = pm;
    tick();
  endtask

  task automatic rel();
    key_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; prog_mode = 1'b0;
    match = 1'b0; alarm_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_unlocked", 8'(unlocked), 8'd0);
    chk("rst_alarm", 8'(alarm), 8'd0);
    chk("rst_code_set", 8'(code_set), 8'd0);
    chk("rst_digit_cnt", 8'(digit_cnt), 8'd0);
    chk("rst_attempt_cnt", 8'(attempt_cnt), 8'd0);
    chk("rst_strobes", 8'({ui_shift, sp_shift, ui_clr}), 8'd0);
    chk("rst_shift_data", 8'(shift_data), 8'd0);
    tick();

    // Entry before any passcode exists is ignored
    press(4'd5, 1'b0);
    chk("early_ui_shift", 8'(ui_shift), 8'd0);
    chk("early_digit_cnt", 8'(digit_cnt), 8'd0);
    rel();

    // Programming; prog_mode dropped on digit 3 must not matter inside PROG
    for (int i = 0; i < 8; i++) begin
      press(good_code[i], i != 3);
      chk("prog_sp_shift", 8'(sp_shift), 8'd1);
      chk("prog_ui_shift", 8'(ui_shift), 8'd0);
      chk("prog_shift_data", 8'(shift_data), 8'(good_code[i]));
      chk("prog_digit_cnt", 8'(digit_cnt), (i == 7) ? 8'd0 : 8'(i + 1));
      chk("prog_code_set", 8'(code_set), (i == 7) ? 8'd1 : 8'd0);
      rel();
      chk("prog_sp_low", 8'(sp_shift), 8'd0);
    end

    // Correct entry; first key held 20 cycles
    match = 1'b1;
    press(good_code[0], 1'b0);
    chk("hold_first", 8'(ui_shift), 8'd1);
    chk("hold_digit_cnt", 8'(digit_cnt), 8'd1);
    n = 0;
    repeat (19) begin
      tick();
      n += int'(ui_shift);
    end
    chk("hold_extra_strobes", 8'(n), 8'd0);
    rel();
    for (int i = 1; i < 8; i++) begin
      press(good_code[i], 1'b0);
      chk("entry_ui_shift", 8'(ui_shift), 8'd1);
      chk("entry_shift_data", 8'(shift_data), 8'(good_code[i]));
      rel();
    end
    chk("open_unlocked", 8'(unlocked), 8'd1);
    chk("open_attempt", 8'(attempt_cnt), 8'd0);
    n = 1;
    repeat (15) begin
      tick();
      n += int'(unlocked);
    end
    chk("open_cycles", 8'(n), 8'd16);
    tick();
    chk("open_end_unlocked", 8'(unlocked), 8'd0);
    chk("open_end_ui_clr", 8'(ui_clr), 8'd1);
    tick();
    chk("open_end_ui_clr_low", 8'(ui_clr), 8'd0);

    // Five failed entries
    match = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      for (int i = 0; i < 8; i++) begin
        press(wrong_code[i], 1'b0);
        chk("fail_ui_shift", 8'(ui_shift), 8'd1);
        rel();
      end
      chk("fail_ui_clr", 8'(ui_clr), 8'd1);
      chk("fail_attempt", 8'(attempt_cnt), 8'(w));
      chk("fail_alarm", 8'(alarm), (w == 5) ? 8'd1 : 8'd0);
      tick();
      chk("fail_ui_clr_low", 8'(ui_clr), 8'd0);
    end
    press(4'd1, 1'b0);
    chk("alarm_no_ui", 8'(ui_shift), 8'd0);
    chk("alarm_held", 8'(alarm), 8'd1);
    rel();
    press(4'd1, 1'b1);
    chk("alarm_no_sp", 8'(sp_shift), 8'd0);
    rel();
    alarm_clr = 1'b1;
    press(4'd2, 1'b0);
    alarm_clr = 1'b0;
    chk("clr_alarm", 8'(alarm), 8'd0);
    chk("clr_attempt", 8'(attempt_cnt), 8'd0);
    chk("clr_ui_clr", 8'(ui_clr), 8'd1);
    chk("clr_key_dropped", 8'(ui_shift), 8'd0);
    rel();
    chk("clr_digit_cnt", 8'(digit_cnt), 8'd0);

    // Timeout after 3 entry digits
    for (int i = 0; i < 3; i++) begin
      press(4'(i + 1), 1'b0);
      rel();
    end
    repeat (253) tick();
    chk("tmo_before_cnt", 8'(digit_cnt), 8'd3);
    chk("tmo_before_clr", 8'(ui_clr), 8'd0);
    tick();
    chk("tmo_digit_cnt", 8'(digit_cnt), 8'd0);
    chk("tmo_ui_clr", 8'(ui_clr), 8'd1);
    chk("tmo_attempt", 8'(attempt_cnt), 8'd0);
    tick();

    // Re-program during OPEN
    match = 1'b1;
    for (int i = 0; i < 8; i++) begin
      press(good_code[i], 1'b0);
      rel();
    end
    chk("reprog_open", 8'(unlocked), 8'd1);
    press(4'd3, 1'b1);
    chk("reprog_unlocked", 8'(unlocked), 8'd0);
    chk("reprog_ui_clr", 8'(ui_clr), 8'd1);
    chk("reprog_sp_shift", 8'(sp_shift), 8'd1);
    chk("reprog_shift_data", 8'(shift_data), 8'd3);
    chk("reprog_code_set", 8'(code_set), 8'd0);
    chk("reprog_digit_cnt", 8'(digit_cnt), 8'd1);
    rel();
    for (int i = 0; i < 7; i++) begin
      press(4'(i + 1), 1'b1);
      chk("reprog_sp", 8'(sp_shift), 8'd1);
      rel();
    end
    chk("reprog_done", 8'(code_set), 8'd1);
    chk("reprog_cnt", 8'(digit_cnt), 8'd0);

    // Reset clears code_set, then reset lands on digit 5 of programming
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_code_set", 8'(code_set), 8'd0);
    for (int i = 0; i < 4; i++) begin
      press(4'(i + 6), 1'b1);
      rel();
    end
    chk("rst3_pre_cnt", 8'(digit_cnt), 8'd4);
    rst = 1'b1;
    press(4'd5, 1'b1);
    rst = 1'b0;
    chk("rst3_sp_shift", 8'(sp_shift), 8'd0);
    chk("rst3_digit_cnt", 8'(digit_cnt), 8'd0);
    chk("rst3_code_set", 8'(code_set), 8'd0);
    chk("rst3_shift_data", 8'(shift_data), 8'd0);
    chk("rst3_others", 8'({ui_shift, ui_clr, unlocked, alarm}), 8'd0);
    chk("rst3_attempt", 8'(attempt_cnt), 8'd0);
    rel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
